instruction_fetch: RTL and testbench

Initiator/reader side of the program ROM interface. It holds the program counter and drives the ROM address and enable. It captures the registered ROM word and presents it to the decoder with a valid/ready handshake. It also handles jumps, halt, and PC wrap-around. Sits between program_memory and the instruction decoder in the Karpentium core.

---
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Reads the program ROM for the Karpentium core. This block holds the program
// counter, drives the ROM address and read enable, captures the ROM's
// registered output word, and hands that word to the decoder through a
// valid/ready handshake. It also handles jumps, halt and PC wrap-around.
//
// Ports
//   clk          system clock; all state updates on posedge
//   reset        asynchronous, active-high; clears all state immediately
//   mem_address  ROM address, always equal to pc
//   mem_enable   ROM read enable, high only in ISSUE
//   mem_data     registered ROM output, valid during CAPTURE
//   instr        last captured instruction word
//   instr_valid  instr holds an instruction the decoder has not consumed
//   instr_ready  decoder accepts instr when instr_valid && instr_ready
//   pc           address of the instruction in instr, or of the pending fetch
//   jump         single-cycle request to redirect fetch to jump_target
//   jump_target  new PC, sampled while jump=1
//   halt         level; stops new fetches at the next HOLD exit
//
// State table
//   state   | meaning
//   ISSUE   | ROM enable high; the ROM samples pc at the closing edge
//   CAPTURE | ROM word on mem_data; it is latched into instr at the closing edge
//   HOLD    | instr_valid high; waiting for the decoder to take the word
//   HALT    | halted; nothing is fetched until halt drops
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                s_addr       = 6,
    parameter int                s_word       = 16,
    parameter logic [s_addr-1:0] reset_vector = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [s_addr-1:0] mem_address,
    output logic              mem_enable,
    input  logic [s_word-1:0] mem_data,
    output logic [s_word-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [s_addr-1:0] pc,
    input  logic              jump,
    input  logic [s_addr-1:0] jump_target,
    input  logic              halt
);

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [s_addr-1:0] pc_next;
    logic [s_word-1:0] instr_next;
    logic              valid_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ISSUE;
            pc          <= reset_vector;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            instr_valid <= valid_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        valid_next = instr_valid;

        if (jump) begin
            // A fetch in flight is dropped: leaving CAPTURE without latching
            // mem_data means that word never reaches the decoder. A handshake
            // on this same edge still counts as consumed, so valid is cleared.
            pc_next    = jump_target;
            valid_next = 1'b0;
            state_next = (state == HALT) ? HALT : ISSUE;
        end else begin
            unique case (state)
                ISSUE: begin
                    state_next = CAPTURE;
                end
                CAPTURE: begin
                    instr_next = mem_data;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
                HOLD: begin
                    if (instr_ready) begin
                        // Wraps modulo 2**s_addr with no flag.
                        pc_next    = pc + s_addr'(1);
                        valid_next = 1'b0;
                        state_next = halt ? HALT : ISSUE;
                    end
                end
                HALT: begin
                    valid_next = 1'b0;
                    if (!halt) state_next = ISSUE;
                end
                default: state_next = ISSUE;
            endcase
        end
    end

    assign mem_address = pc;
    assign mem_enable  = (state == ISSUE);

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. Two instances share one clock:
// dut starts from reset vector 0, and dut_w starts from 62 to exercise PC
// wrap-around. Each instance reads a registered ROM model that holds
// 16'h1000 + address and drives 16'hDEAD on cycles when it is not enabled.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  mem_address;
    logic        mem_enable;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  pc;
    logic        jump;
    logic [5:0]  jump_target;
    logic        halt;

    logic        reset_w;
    logic [5:0]  mem_address_w;
    logic        mem_enable_w;
    logic [15:0] mem_data_w;
    logic [15:0] instr_w;
    logic        instr_valid_w;
    logic        instr_ready_w;
    logic [5:0]  pc_w;
    logic        jump_w;
    logic [5:0]  jump_target_w;
    logic        halt_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.s_addr(6), .s_word(16), .reset_vector(6'd0)) dut (
        .clk(clk), .reset(reset), .mem_address(mem_address), .mem_enable(mem_enable),
        .mem_data(mem_data), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .jump(jump), .jump_target(jump_target),
        .halt(halt)
    );

    instruction_fetch #(.s_addr(6), .s_word(16), .reset_vector(6'd62)) dut_w (
        .clk(clk), .reset(reset_w), .mem_address(mem_address_w), .mem_enable(mem_enable_w),
        .mem_data(mem_data_w), .instr(instr_w), .instr_valid(instr_valid_w),
        .instr_ready(instr_ready_w), .pc(pc_w), .jump(jump_w), .jump_target(jump_target_w),
        .halt(halt_w)
    );

    function automatic logic [15:0] rom_word(input logic [5:0] a);
        return 16'h1000 + {10'd0, a};
    endfunction

    always @(posedge clk) begin
        mem_data   <= mem_enable   ? rom_word(mem_address)   : 16'hDEAD;
        mem_data_w <= mem_enable_w ? rom_word(mem_address_w) : 16'hDEAD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves dut in ISSUE at reset_vector, 1 time unit after a posedge.
    task automatic restart();
        reset = 1'b1; instr_ready = 1'b0; jump = 1'b0; jump_target = '0; halt = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_ready = 1'b0; jump = 1'b0; jump_target = '0; halt = 1'b0;
        tick();
        checks++;
        if (pc !== 6'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++;
        if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instr); end
        checks++;
        if (mem_address !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_address); end
        reset = 1'b0;
        checks++;
        if (mem_enable !== 1'b1) begin errors++; $display("FAIL reset_release_enable got %b want 1", mem_enable); end
    endtask

    task automatic test_sequential();
        restart();
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem_enable !== 1'b1 || pc !== 6'(k) || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_issue k=%0d got en=%b pc=%0d v=%b want en=1 pc=%0d v=0", k, mem_enable, pc, instr_valid, k);
            end
            tick();
            checks++;
            if (mem_enable !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_capture k=%0d got en=%b v=%b want en=0 v=0", k, mem_enable, instr_valid);
            end
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== rom_word(6'(k)) || pc !== 6'(k) || mem_enable !== 1'b0) begin
                errors++;
                $display("FAIL seq_hold k=%0d got v=%b instr=%h pc=%0d en=%b want v=1 instr=%h pc=%0d en=0",
                         k, instr_valid, instr, pc, mem_enable, rom_word(6'(k)), k);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        restart();
        instr_ready = 1'b0;
        run_ticks(2);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'h1000 || pc !== 6'd0 || mem_enable !== 1'b0) begin
                errors++;
                $display("FAIL backpressure c=%0d got v=%b instr=%h pc=%0d en=%b want v=1 instr=1000 pc=0 en=0",
                         c, instr_valid, instr, pc, mem_enable);
            end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (pc !== 6'd1 || instr_valid !== 1'b0 || mem_enable !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release got pc=%0d v=%b en=%b want pc=1 v=0 en=1", pc, instr_valid, mem_enable);
        end
    endtask

    task automatic test_jump();
        restart();
        instr_ready = 1'b1;
        run_ticks(9);
        tick();
        checks++;
        if (pc !== 6'd3 || mem_enable !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_setup got pc=%0d en=%b v=%b want pc=3 en=0 v=0", pc, mem_enable, instr_valid);
        end
        jump = 1'b1; jump_target = 6'd40;
        tick();
        jump = 1'b0; jump_target = 6'd0;
        checks++;
        if (pc !== 6'd40 || instr_valid !== 1'b0 || mem_enable !== 1'b1) begin
            errors++;
            $display("FAIL jump_redirect got pc=%0d v=%b en=%b want pc=40 v=0 en=1", pc, instr_valid, mem_enable);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL jump_no_stale got v=%b instr=%h want v=0", instr_valid, instr); end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h1028 || pc !== 6'd40) begin
            errors++;
            $display("FAIL jump_target_word got v=%b instr=%h pc=%0d want v=1 instr=1028 pc=40", instr_valid, instr, pc);
        end
    endtask

    task automatic test_halt();
        restart();
        instr_ready = 1'b1;
        run_ticks(16);
        instr_ready = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc !== 6'd5 || instr !== 16'h1005) begin
            errors++;
            $display("FAIL halt_setup got v=%b pc=%0d instr=%h want v=1 pc=5 instr=1005", instr_valid, pc, instr);
        end
        halt = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc !== 6'd5) begin
            errors++;
            $display("FAIL halt_keeps_hold got v=%b pc=%0d want v=1 pc=5", instr_valid, pc);
        end
        instr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b0 || mem_enable !== 1'b0 || pc !== 6'd6) begin
                errors++;
                $display("FAIL halt_idle c=%0d got v=%b en=%b pc=%0d want v=0 en=0 pc=6", c, instr_valid, mem_enable, pc);
            end
        end
        halt = 1'b0;
        tick();
        checks++;
        if (mem_enable !== 1'b1 || pc !== 6'd6) begin
            errors++;
            $display("FAIL halt_resume got en=%b pc=%0d want en=1 pc=6", mem_enable, pc);
        end
        run_ticks(2);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h1006 || pc !== 6'd6) begin
            errors++;
            $display("FAIL halt_resume_word got v=%b instr=%h pc=%0d want v=1 instr=1006 pc=6", instr_valid, instr, pc);
        end
    endtask

    task automatic test_reset_midop();
        restart();
        instr_ready = 1'b1;
        run_ticks(28);
        checks++;
        if (pc !== 6'd9 || mem_enable !== 1'b0) begin
            errors++;
            $display("FAIL midop_setup got pc=%0d en=%b want pc=9 en=0", pc, mem_enable);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (pc !== 6'd0 || instr_valid !== 1'b0 || mem_address !== 6'd0) begin
            errors++;
            $display("FAIL midop_async got pc=%0d v=%b addr=%0d want pc=0 v=0 addr=0", pc, instr_valid, mem_address);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (mem_enable !== 1'b1 || pc !== 6'd0) begin
            errors++;
            $display("FAIL midop_restart got en=%b pc=%0d want en=1 pc=0", mem_enable, pc);
        end
        run_ticks(2);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h1000 || pc !== 6'd0) begin
            errors++;
            $display("FAIL midop_first_word got v=%b instr=%h pc=%0d want v=1 instr=1000 pc=0", instr_valid, instr, pc);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_pc;
        instr_ready_w = 1'b1;
        reset_w = 1'b0;
        exp_pc = 6'd62;
        for (int k = 0; k < 4; k++) begin
            run_ticks(2);
            checks++;
            if (instr_valid_w !== 1'b1 || pc_w !== exp_pc || instr_w !== rom_word(exp_pc)) begin
                errors++;
                $display("FAIL wrap k=%0d got v=%b pc=%0d instr=%h want v=1 pc=%0d instr=%h",
                         k, instr_valid_w, pc_w, instr_w, exp_pc, rom_word(exp_pc));
            end
            exp_pc = exp_pc + 6'd1;
            tick();
        end
    endtask

    // Transaction-level scoreboard: tracks the next address the decoder should
    // see, bumped by each accepted handshake and replaced by each jump, and the
    // number of edges since the last redirect (a word must appear after two).
    task automatic test_random();
        logic [5:0] exp_pc;
        logic       prev_valid, prev_ready, prev_jump;
        logic [5:0] prev_target;
        int         since;
        restart();
        exp_pc = 6'd0;
        since = 0;
        for (int n = 0; n < 500; n++) begin
            instr_ready = ($urandom_range(0, 1) == 1);
            jump        = ($urandom_range(0, 7) == 0);
            jump_target = 6'($urandom_range(0, 63));
            prev_valid  = instr_valid;
            prev_ready  = instr_ready;
            prev_jump   = jump;
            prev_target = jump_target;
            tick();
            if (prev_jump) begin
                exp_pc = prev_target;
                since = 0;
            end else if (prev_valid && prev_ready) begin
                exp_pc = exp_pc + 6'd1;
                since = 0;
            end else if (!prev_valid) begin
                since++;
            end
            checks++;
            if (pc !== exp_pc || mem_address !== exp_pc) begin
                errors++;
                $display("FAIL rand_pc n=%0d got pc=%0d addr=%0d want %0d", n, pc, mem_address, exp_pc);
            end
            if (instr_valid) begin
                checks++;
                if (instr !== rom_word(exp_pc) || (!prev_valid && since != 2) || (prev_valid && (prev_jump || prev_ready))) begin
                    errors++;
                    $display("FAIL rand_word n=%0d got instr=%h since=%0d want instr=%h since=2",
                             n, instr, since, rom_word(exp_pc));
                end
            end else begin
                checks++;
                if ((!prev_jump && prev_valid && !prev_ready) || since >= 2) begin
                    errors++;
                    $display("FAIL rand_valid n=%0d got v=0 since=%0d want v=1", n, since);
                end
            end
        end
        jump = 1'b0;
        instr_ready = 1'b0;
    endtask

    initial begin
        reset_w = 1'b1; instr_ready_w = 1'b0; jump_w = 1'b0; jump_target_w = '0; halt_w = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_jump();
        test_halt();
        test_reset_midop();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
